adsr_envelope_gen: RTL and testbench
====================================

# adsr_envelope_gen

Per-voice ADSR envelope generator and amplitude stage. Tracks a gate signal through attack/decay/sustain/release at the sample rate and scales one oscillator's signed sample by the current envelope level. One instance per voice; each `dout` feeds one input of the multi-channel mixer.

## Interface

- `DATA_BITS`, 12: sample width, two's complement, for `din` and `dout`.
- `ENV_BITS`, 16: envelope accumulator width, unsigned; full scale `ENV_MAX = 2**ENV_BITS-1`.

Ports:

- `clk`  in  1  system clock. One clock domain; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `sample_tick`  in  1  one-cycle strobe at the sample rate. All envelope updates occur only on tick cycles.
- `gate`  in  1  note on (1) or off (0). Sampled only on tick cycles.
- `attack_inc`  in  ENV_BITS  amount added per tick in ATTACK.
- `decay_dec`  in  ENV_BITS  amount subtracted per tick in DECAY.
- `sustain`  in  ENV_BITS  sustain level.
- `release_dec`  in  ENV_BITS  amount subtracted per tick in RELEASE.
- `din`  in  DATA_BITS  signed oscillator sample.
- `dout`  out  DATA_BITS  signed scaled sample, registered.
- `env`  out  ENV_BITS  current envelope level, registered.
- `state`  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `active`  out  1  registered; 1 when `state != IDLE`.

## Operation

- Reset: `state`=IDLE, `env`=0, `dout`=0, `active`=0, `gate_prev`=0.
- `rst` dominates `sample_tick`. Reset mid-note returns to IDLE with no residual level.
- `gate_prev` holds `gate` as sampled on the previous tick. A rising edge is `gate & ~gate_prev` on a tick.
- Non-tick cycles: `state`, `env` and `gate_prev` hold.
- Tick transitions. Arithmetic is ENV_BITS+1 wide, so there is no wrap.
  - IDLE: `env`=0. A rising edge goes to ATTACK.
  - ATTACK:
    - If `gate`=0: go to RELEASE; `env` is unchanged this tick.
    - Else if `env + attack_inc >= ENV_MAX`: `env`=ENV_MAX, go to DECAY.
    - Else `env += attack_inc`.
  - DECAY:
    - If `gate`=0: go to RELEASE; `env` is unchanged.
    - Else if `env <= sustain + decay_dec`: `env`=`sustain`, go to SUSTAIN.
    - Else `env -= decay_dec`.
  - SUSTAIN:
    - `env`=`sustain` each tick, so live changes are tracked.
    - If `gate`=0: go to RELEASE.
  - RELEASE:
    - A rising edge goes to ATTACK (retrigger; see Configuration).
    - Else if `env <= release_dec`: `env`=0, go to IDLE.
    - Else `env -= release_dec`.
- A rising edge in ATTACK, DECAY or SUSTAIN is impossible without an intervening `gate`=0 tick, which already moved the FSM to RELEASE.
- Zero rates:
  - `attack_inc`=0 stalls in ATTACK while gated.
  - `release_dec`=0 holds RELEASE until `env`=0 or retrigger.
  - `decay_dec`=0 holds DECAY unless `env <= sustain`.
- A `sustain` above the current `env` in DECAY snaps `env` up to `sustain`.
- Scaling, every cycle: `dout <= (din * {1'b0, env}) >>> ENV_BITS`.
  - Signed multiply, arithmetic shift (floor), truncated to DATA_BITS.
  - No overflow is possible, since `env < 2**ENV_BITS`.

## Timing

- A tick at edge N updates `state`, `env` and `active`, which are visible after edge N.
- `dout` is registered from the `din` and `env` present at each edge: one-cycle latency from `din`, and it reflects a new `env` one cycle after `env` changes.
- `gate` is ignored between ticks. A gate pulse that falls entirely between two ticks is lost.
- Back-to-back ticks, one every cycle, are supported.

## Configuration

- `ADSR_HARD_RETRIGGER_EN`
  - Defined: a rising edge (from IDLE or RELEASE) forces `env`=0 on that tick before ATTACK begins. The next tick adds `attack_inc` from 0.
  - Undefined (default): retrigger enters ATTACK with `env` unchanged. This is a click-free legato restart.

## Test plan

- Attack/decay/sustain path: `attack_inc`=0x1000, `decay_dec`=0x1000, `sustain`=0x8000, `gate`=1.
  - 16 ticks reach `env`=0xFFFF and DECAY.
  - 7 ticks reach `env`=0x8FFF, and the 8th gives 0x8000 in SUSTAIN.
- Release: from SUSTAIN at 0x8000 with `release_dec`=0x2000, drop `gate`.
  - RELEASE, then `env` goes 0x6000, 0x4000, 0x2000, then 0 and IDLE with `active`=0.
- Gate drop mid-attack: `gate`=0 at `env`=0x3000.
  - The next tick enters RELEASE with `env`=0x3000, then decrements.
- Retrigger in RELEASE at `env`=0x4000:
  - Without macro: ATTACK at 0x4000.
  - With `ADSR_HARD_RETRIGGER_EN`: ATTACK at 0.
- Scaling:
  - `din`=1000, `env`=0xFFFF gives `dout`=999.
  - `din`=-1000 gives -1000.
  - `env`=0x8000, `din`=1000 gives 500.
  - `env`=0 gives 0. `dout` changes one cycle after `din`.
- `rst` asserted on a tick cycle during ATTACK:
  - The next cycle shows IDLE, `env`=0, `active`=0 and `dout`=0.
  - The tick is ignored.

Source files
------------

// File: rtl/adsr_envelope_gen.sv
// Per-voice ADSR envelope generator with signed amplitude scaling of one oscillator sample.
// Optional ADSR_HARD_RETRIGGER_EN: a rising gate edge zeroes env before ATTACK begins.
module adsr_envelope_gen #(
    parameter int DATA_BITS = 12,
    parameter int ENV_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 gate,
    input  logic [ENV_BITS-1:0]  attack_inc,
    input  logic [ENV_BITS-1:0]  decay_dec,
    input  logic [ENV_BITS-1:0]  sustain,
    input  logic [ENV_BITS-1:0]  release_dec,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic [ENV_BITS-1:0]  env,
    output logic [2:0]           state,
    output logic                 active
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } state_t;

    localparam logic [ENV_BITS:0] EnvMax = {1'b0, {ENV_BITS{1'b1}}};

    state_t                state_q, state_d;
    logic [ENV_BITS-1:0]   env_q, env_d;
    logic                  gate_prev_q, gate_prev_d;
    logic                  active_q, active_d;
    logic [DATA_BITS-1:0]  dout_q, dout_d;

    logic                  rise;
    logic [ENV_BITS:0]     sum_att;
    logic [ENV_BITS:0]     sus_plus_dec;
    logic signed [DATA_BITS+ENV_BITS:0] prod;

    always_comb begin
        state_d      = state_q;
        env_d        = env_q;
        gate_prev_d  = gate_prev_q;
        rise         = gate & ~gate_prev_q;
        // One extra bit so attack overshoot and sustain+decay never wrap.
        sum_att      = {1'b0, env_q} + {1'b0, attack_inc};
        sus_plus_dec = {1'b0, sustain} + {1'b0, decay_dec};

        if (sample_tick) begin
            gate_prev_d = gate;
            case (state_q)
                StIdle: begin
                    env_d = '0;
                    if (rise) begin
                        state_d = StAttack;
                    end
                end
                StAttack: begin
                    if (!gate) begin
                        state_d = StRelease;
                    end else if (sum_att >= EnvMax) begin
                        env_d   = EnvMax[ENV_BITS-1:0];
                        state_d = StDecay;
                    end else begin
                        env_d = sum_att[ENV_BITS-1:0];
                    end
                end
                StDecay: begin
                    if (!gate) begin
                        state_d = StRelease;
                    end else if ({1'b0, env_q} <= sus_plus_dec) begin
                        env_d   = sustain;
                        state_d = StSustain;
                    end else begin
                        env_d = env_q - decay_dec;
                    end
                end
                StSustain: begin
                    env_d = sustain;
                    if (!gate) begin
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    if (rise) begin
                        state_d = StAttack;
`ifdef ADSR_HARD_RETRIGGER_EN
                        env_d = '0;
`else
                        env_d = env_q;
`endif
                    end else if (env_q <= release_dec) begin
                        env_d   = '0;
                        state_d = StIdle;
                    end else begin
                        env_d = env_q - release_dec;
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = StIdle;
                end
            endcase
        end

        active_d = (state_d != StIdle);
        // env is unsigned, so zero-extend before the signed multiply; floor shift, then truncate.
        prod   = $signed(din) * $signed({1'b0, env_q});
        dout_d = DATA_BITS'(prod >>> ENV_BITS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            env_q       <= '0;
            gate_prev_q <= 1'b0;
            active_q    <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            env_q       <= env_d;
            gate_prev_q <= gate_prev_d;
            active_q    <= active_d;
            dout_q      <= dout_d;
        end
    end

    assign state  = state_q;
    assign env    = env_q;
    assign active = active_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Scoreboard bench for adsr_envelope_gen: driver queues hand-computed expectations,
// monitor pops and compares after every tick or probe cycle.
module tb_adsr_envelope_gen;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ATT  = 3'd1;
    localparam logic [2:0] S_DEC  = 3'd2;
    localparam logic [2:0] S_SUS  = 3'd3;
    localparam logic [2:0] S_REL  = 3'd4;
`ifdef ADSR_HARD_RETRIGGER_EN
    localparam bit HARD = 1'b1;
`else
    localparam bit HARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, sample_tick, gate, probe;
    logic [15:0] attack_inc, decay_dec, sustain, release_dec;
    logic [11:0] din;
    logic [11:0] dout;
    logic [15:0] env;
    logic [2:0]  state;
    logic        active;

    typedef struct packed {
        logic        cs;
        logic [2:0]  st;
        logic        ce;
        logic [15:0] e;
        logic        cd;
        logic [11:0] d;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    adsr_envelope_gen #(.DATA_BITS(12), .ENV_BITS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .gate        (gate),
        .attack_inc  (attack_inc),
        .decay_dec   (decay_dec),
        .sustain     (sustain),
        .release_dec (release_dec),
        .din         (din),
        .dout        (dout),
        .env         (env),
        .state       (state),
        .active      (active)
    );

    task automatic push(input string nm, input logic cs, input logic [2:0] st, input logic ce,
                        input logic [15:0] e, input logic cd, input logic [11:0] d);
        exp_t x;
        x.cs = cs; x.st = st; x.ce = ce; x.e = e; x.cd = cd; x.d = d;
        sb_q.push_back(x);
        nm_q.push_back(nm);
    endtask

    task automatic tk(input string nm, input logic [2:0] st, input logic [15:0] e);
        sample_tick = 1'b1;
        push(nm, 1'b1, st, 1'b1, e, 1'b0, 12'd0);
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic pr(input string nm, input logic [11:0] d);
        probe = 1'b1;
        push(nm, 1'b0, 3'd0, 1'b0, 16'd0, 1'b1, d);
        @(negedge clk);
        probe = 1'b0;
    endtask

    // Monitor: one expectation per tick/probe edge, compared half a cycle later.
    initial begin
        exp_t  x;
        string nm;
        forever begin
            @(posedge clk);
            if (sample_tick || probe) begin
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: DUT output with no expectation queued");
                end else begin
                    x  = sb_q.pop_front();
                    nm = nm_q.pop_front();
                    if (x.cs) begin
                        checks += 2;
                        if (state !== x.st) begin
                            errors++;
                            $display("FAIL %s state: got %0d want %0d", nm, state, x.st);
                        end
                        if (active !== (x.st != S_IDLE)) begin
                            errors++;
                            $display("FAIL %s active: got %0b want %0b", nm, active,
                                     x.st != S_IDLE);
                        end
                    end
                    if (x.ce) begin
                        checks++;
                        if (env !== x.e) begin
                            errors++;
                            $display("FAIL %s env: got %h want %h", nm, env, x.e);
                        end
                    end
                    if (x.cd) begin
                        checks++;
                        if (dout !== x.d) begin
                            errors++;
                            $display("FAIL %s dout: got %0d want %0d", nm, $signed(dout),
                                     $signed(x.d));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e0;
        rst = 1'b1; sample_tick = 1'b0; gate = 1'b0; probe = 1'b0;
        attack_inc = 16'h1000; decay_dec = 16'h1000; sustain = 16'h8000;
        release_dec = 16'h2000; din = 12'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        probe = 1'b1;
        push("reset", 1'b1, S_IDLE, 1'b1, 16'h0000, 1'b1, 12'd0);
        @(negedge clk);
        probe = 1'b0;

        // Attack: rising edge enters ATTACK, 16 more ticks saturate into DECAY.
        gate = 1'b1;
        tk("att_enter", S_ATT, 16'h0000);
        for (int k = 1; k <= 15; k++) begin
            tk($sformatf("att%0d", k), S_ATT, 16'(k * 4096));
        end
        tk("att_sat", S_DEC, 16'hFFFF);

        // Scaling at full scale; dout follows din with one cycle of latency.
        din = 12'd1000;
        pr("scale_full_pos", 12'd999);
        din = -12'sd1000;
        pr("scale_full_neg", -12'sd1000);
        din = 12'd1000;
        pr("scale_full_back", 12'd999);

        for (int k = 1; k <= 7; k++) begin
            tk($sformatf("dec%0d", k), S_DEC, 16'(16'hFFFF - k * 4096));
        end
        tk("dec_to_sus", S_SUS, 16'h8000);
        @(negedge clk);
        pr("scale_half", 12'd500);

        sustain = 16'h7000;
        tk("sus_track_lo", S_SUS, 16'h7000);
        sustain = 16'h8000;
        tk("sus_track_hi", S_SUS, 16'h8000);

        // Release down to idle.
        gate = 1'b0;
        tk("rel_enter", S_REL, 16'h8000);
        tk("rel1", S_REL, 16'h6000);
        tk("rel2", S_REL, 16'h4000);
        tk("rel3", S_REL, 16'h2000);
        tk("rel_idle", S_IDLE, 16'h0000);
        @(negedge clk);
        pr("scale_zero", 12'd0);

        // Gate drop mid-attack.
        gate = 1'b1;
        tk("mid_enter", S_ATT, 16'h0000);
        tk("mid1", S_ATT, 16'h1000);
        tk("mid2", S_ATT, 16'h2000);
        tk("mid3", S_ATT, 16'h3000);
        gate = 1'b0;
        tk("mid_rel", S_REL, 16'h3000);
        tk("mid_rel1", S_REL, 16'h1000);
        tk("mid_idle", S_IDLE, 16'h0000);

        // Retrigger from RELEASE at 0x4000.
        gate = 1'b1;
        tk("rt_enter", S_ATT, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            tk($sformatf("rt_att%0d", k), S_ATT, 16'(k * 4096));
        end
        gate = 1'b0;
        tk("rt_rel", S_REL, 16'h4000);
        gate = 1'b1;
        e0 = HARD ? 16'h0000 : 16'h4000;
        tk("retrigger", S_ATT, e0);
        tk("rt_next", S_ATT, e0 + 16'h1000);

        // A gate pulse confined between ticks is never seen.
        gate = 1'b0;
        repeat (2) @(negedge clk);
        gate = 1'b1;
        tk("gate_between", S_ATT, e0 + 16'h2000);

        // Reset on a tick cycle wins over the tick.
        rst = 1'b1;
        sample_tick = 1'b1;
        push("rst_on_tick", 1'b1, S_IDLE, 1'b1, 16'h0000, 1'b1, 12'd0);
        @(negedge clk);
        rst = 1'b0;
        sample_tick = 1'b0;

        // gate_prev cleared by reset, so held gate reads as a fresh edge.
        tk("post_rst_edge", S_ATT, 16'h0000);
        attack_inc = 16'h0000;
        tk("att_zero_stall", S_ATT, 16'h0000);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
